// File: rtl/video_timing_measure.sv
// rtl/video_timing_measure.sv - sync/de geometry analyser with per-frame publish and lock detection
module video_timing_measure #(
    parameter int CNT_W       = 16,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             hpol_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             de_i,
    output logic [CNT_W-1:0] htotal_o,
    output logic [CNT_W-1:0] hsw_o,
    output logic [CNT_W-1:0] hactive_o,
    output logic [CNT_W-1:0] vtotal_o,
    output logic [CNT_W-1:0] vsw_o,
    output logic [CNT_W-1:0] vactive_o,
    output logic             locked_o,
    output logic             frame_done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_N   = LOCK_FRAMES[3:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t state;

    logic hs, vs, de, hs_d, vs_d;
    logic hs_edge, vs_edge, watchdog;

    logic [CNT_W-1:0] pix_cnt, hsw_cnt, de_cnt;
    logic [CNT_W-1:0] htotal_line, hsw_line;
    logic [CNT_W-1:0] line_cnt, vsw_cnt, vact_cnt, hact_frame;
    logic             hact_seen, frame_bad;
    logic [3:0]       match_cnt;

    logic [CNT_W-1:0] htot_nxt, hsw_nxt, hact_nxt, line_nxt, vsw_nxt, vact_nxt;
    logic             seen_nxt, bad_nxt, tuple_eq;
    logic [3:0]       match_new;

    // Syncs are normalised so that 1 always means "asserted"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs   <= 1'b0;
            vs   <= 1'b0;
            de   <= 1'b0;
            hs_d <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            hs   <= hsync_i ^ ~hpol_i;
            vs   <= vsync_i ^ ~hpol_i;
            de   <= de_i;
            hs_d <= hs;
            vs_d <= vs;
        end
    end

    assign hs_edge  = hs & ~hs_d;
    assign vs_edge  = vs & ~vs_d;
    assign watchdog = (pix_cnt == CNT_MAX) && !hs_edge;

    // Line close folded in combinationally so a coincident frame close sees it
    always_comb begin
        htot_nxt = htotal_line;
        hsw_nxt  = hsw_line;
        line_nxt = line_cnt;
        vsw_nxt  = vsw_cnt;
        vact_nxt = vact_cnt;
        hact_nxt = hact_frame;
        seen_nxt = hact_seen;
        bad_nxt  = frame_bad;
        if (hs_edge) begin
            htot_nxt = pix_cnt;
            hsw_nxt  = hsw_cnt;
            line_nxt = sat_inc(line_cnt);
            if (vs) begin
                vsw_nxt = sat_inc(vsw_cnt);
            end
            if (de_cnt != CNT_ZERO) begin
                vact_nxt = sat_inc(vact_cnt);
                hact_nxt = de_cnt;
                seen_nxt = 1'b1;
                if (hact_seen && (de_cnt != hact_frame)) begin
                    bad_nxt = 1'b1;
                end
            end
        end
    end

    assign tuple_eq = (htot_nxt == htotal_o) && (hsw_nxt == hsw_o) &&
                      (hact_nxt == hactive_o) && (line_nxt == vtotal_o) &&
                      (vsw_nxt == vsw_o) && (vact_nxt == vactive_o);

    // Cleared outputs start match_cnt at 0, so the first publish lands on 1 either way
    assign match_new = bad_nxt  ? 4'd0 :
                       tuple_eq ? ((match_cnt == 4'hf) ? 4'hf : match_cnt + 4'd1) :
                                  4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt     <= CNT_ZERO;
            hsw_cnt     <= CNT_ZERO;
            de_cnt      <= CNT_ZERO;
            htotal_line <= CNT_ZERO;
            hsw_line    <= CNT_ZERO;
        end else if (!en_i || state == ST_IDLE) begin
            pix_cnt     <= CNT_ZERO;
            hsw_cnt     <= CNT_ZERO;
            de_cnt      <= CNT_ZERO;
            htotal_line <= CNT_ZERO;
            hsw_line    <= CNT_ZERO;
        end else begin
            htotal_line <= htot_nxt;
            hsw_line    <= hsw_nxt;
            if (hs_edge) begin
                pix_cnt <= CNT_ONE;
                hsw_cnt <= CNT_ONE;
                de_cnt  <= de ? CNT_ONE : CNT_ZERO;
            end else begin
                pix_cnt <= sat_inc(pix_cnt);
                if (hs) begin
                    hsw_cnt <= sat_inc(hsw_cnt);
                end
                if (de) begin
                    de_cnt <= sat_inc(de_cnt);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            line_cnt     <= CNT_ZERO;
            vsw_cnt      <= CNT_ZERO;
            vact_cnt     <= CNT_ZERO;
            hact_frame   <= CNT_ZERO;
            hact_seen    <= 1'b0;
            frame_bad    <= 1'b0;
            match_cnt    <= 4'd0;
            htotal_o     <= CNT_ZERO;
            hsw_o        <= CNT_ZERO;
            hactive_o    <= CNT_ZERO;
            vtotal_o     <= CNT_ZERO;
            vsw_o        <= CNT_ZERO;
            vactive_o    <= CNT_ZERO;
            locked_o     <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else if (!en_i) begin
            state        <= ST_IDLE;
            line_cnt     <= CNT_ZERO;
            vsw_cnt      <= CNT_ZERO;
            vact_cnt     <= CNT_ZERO;
            hact_frame   <= CNT_ZERO;
            hact_seen    <= 1'b0;
            frame_bad    <= 1'b0;
            match_cnt    <= 4'd0;
            htotal_o     <= CNT_ZERO;
            hsw_o        <= CNT_ZERO;
            hactive_o    <= CNT_ZERO;
            vtotal_o     <= CNT_ZERO;
            vsw_o        <= CNT_ZERO;
            vactive_o    <= CNT_ZERO;
            locked_o     <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;

            if (state == ST_IDLE || vs_edge) begin
                line_cnt   <= CNT_ZERO;
                vsw_cnt    <= CNT_ZERO;
                vact_cnt   <= CNT_ZERO;
                hact_frame <= CNT_ZERO;
                hact_seen  <= 1'b0;
                frame_bad  <= 1'b0;
            end else begin
                line_cnt   <= line_nxt;
                vsw_cnt    <= vsw_nxt;
                vact_cnt   <= vact_nxt;
                hact_frame <= hact_nxt;
                hact_seen  <= seen_nxt;
                frame_bad  <= bad_nxt;
            end

            case (state)
                ST_IDLE: begin
                    state <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (vs_edge) begin
                        state <= ST_MEASURE;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (watchdog) begin
                        // Lost hsync: results from the last good frame stay visible
                        state     <= ST_SEARCH;
                        locked_o  <= 1'b0;
                        err_o     <= 1'b1;
                        match_cnt <= 4'd0;
                    end else if (vs_edge) begin
                        htotal_o     <= htot_nxt;
                        hsw_o        <= hsw_nxt;
                        hactive_o    <= hact_nxt;
                        vtotal_o     <= line_nxt;
                        vsw_o        <= vsw_nxt;
                        vactive_o    <= vact_nxt;
                        frame_done_o <= 1'b1;
                        match_cnt    <= match_new;
                        if (state == ST_MEASURE) begin
                            if (match_new == LOCK_N) begin
                                state    <= ST_LOCKED;
                                locked_o <= 1'b1;
                            end
                        end else if (bad_nxt || !tuple_eq) begin
                            state    <= ST_MEASURE;
                            locked_o <= 1'b0;
                            err_o    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_measure.sv
// tb/tb_video_timing_measure.sv - directed bench for video_timing_measure on a small raster
module tb_video_timing_measure;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          hpol = 1'b0;
    logic          hsync = 1'b1;
    logic          vsync = 1'b1;
    logic          de = 1'b0;
    logic [CW-1:0] htotal_o, hsw_o, hactive_o, vtotal_o, vsw_o, vactive_o;
    logic          locked_o, frame_done_o, err_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit pol_high = 1'b0;

    video_timing_measure #(.CNT_W(CW), .LOCK_FRAMES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .hpol_i       (hpol),
        .hsync_i      (hsync),
        .vsync_i      (vsync),
        .de_i         (de),
        .htotal_o     (htotal_o),
        .hsw_o        (hsw_o),
        .hactive_o    (hactive_o),
        .vtotal_o     (vtotal_o),
        .vsw_o        (vsw_o),
        .vactive_o    (vactive_o),
        .locked_o     (locked_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done_o) done_cnt++;
        if (err_o) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tuple(input string tag, input int ht, input int hw, input int ha,
                               input int vt, input int vw, input int va);
        check({tag, "_htotal"}, 32'(htotal_o), ht);
        check({tag, "_hsw"}, 32'(hsw_o), hw);
        check({tag, "_hactive"}, 32'(hactive_o), ha);
        check({tag, "_vtotal"}, 32'(vtotal_o), vt);
        check({tag, "_vsw"}, 32'(vsw_o), vw);
        check({tag, "_vactive"}, 32'(vactive_o), va);
    endtask

    task automatic tick(input bit h, input bit v, input bit d);
        @(posedge clk);
        #1;
        hsync = pol_high ? h : ~h;
        vsync = pol_high ? v : ~v;
        de    = d;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Line: hsync 3, back porch 5, active hact, front porch 4
    task automatic drive_line(input int hact, input int dew, input bit v, input bit act);
        for (int c = 0; c < 12 + hact; c++)
            tick(c < 3, v, act && c >= 8 && c < 8 + dew);
    endtask

    // Frame: vsync 2, back porch 3, active 6, front porch 2 lines
    task automatic drive_frame(input int hact, input bit bad);
        for (int l = 0; l < 13; l++)
            drive_line(hact, (bad && l == 6) ? hact - 4 : hact, l < 2, l >= 5 && l < 11);
    endtask

    initial begin
        int wd_at;
        int err_before;

        idle(3);
        check_tuple("reset", 0, 0, 0, 0, 0, 0);
        check("reset_locked", 32'(locked_o), 0);
        rst_n = 1'b1;
        idle(2);
        en = 1'b1;
        idle(300);
        check("search_no_err", err_cnt, 0);
        check("search_no_done", done_cnt, 0);
        check("search_htotal", 32'(htotal_o), 0);

        drive_frame(16, 1'b0);
        check("f1_done", done_cnt, 0);
        drive_frame(16, 1'b0);
        check("f2_done", done_cnt, 1);
        check_tuple("f2", 28, 3, 16, 13, 2, 6);
        check("f2_locked", 32'(locked_o), 0);
        drive_frame(16, 1'b0);
        check("f3_done", done_cnt, 2);
        check("f3_locked", 32'(locked_o), 1);
        check("f3_err", err_cnt, 0);

        drive_frame(12, 1'b0);
        check("f4_locked", 32'(locked_o), 1);
        check("f4_err", err_cnt, 0);
        drive_frame(12, 1'b0);
        check("f5_err", err_cnt, 1);
        check("f5_locked", 32'(locked_o), 0);
        check_tuple("f5", 24, 3, 12, 13, 2, 6);
        drive_frame(12, 1'b0);
        check("f6_locked", 32'(locked_o), 1);

        drive_frame(12, 1'b1);
        check("f7_locked", 32'(locked_o), 1);
        drive_frame(12, 1'b0);
        check("f8_err", err_cnt, 2);
        check("f8_locked", 32'(locked_o), 0);
        check("f8_hactive", 32'(hactive_o), 12);
        drive_frame(12, 1'b0);
        check("f9_locked_after_bad", 32'(locked_o), 0);
        drive_frame(12, 1'b0);
        check("f10_locked", 32'(locked_o), 1);
        check("f10_done", done_cnt, 9);

        for (int l = 0; l < 4; l++) drive_line(12, 12, l < 2, 1'b0);
        check("f11_done", done_cnt, 10);
        en = 1'b0;
        @(posedge clk);
        #1;
        check_tuple("endrop", 0, 0, 0, 0, 0, 0);
        check("endrop_locked", 32'(locked_o), 0);

        hpol = 1'b1;
        pol_high = 1'b1;
        idle(5);
        en = 1'b1;
        idle(5);
        drive_frame(16, 1'b0);
        check("hi_fa_done", done_cnt, 10);
        drive_frame(16, 1'b0);
        check("hi_fb_done", done_cnt, 11);
        check_tuple("hi_fb", 28, 3, 16, 13, 2, 6);
        check("hi_fb_locked", 32'(locked_o), 0);
        drive_frame(16, 1'b0);
        check("hi_fc_locked", 32'(locked_o), 1);
        check("hi_fc_err", err_cnt, 2);

        wd_at = -1;
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (err_o && wd_at < 0) wd_at = i;
        end
        check("wd_fired", 32'(wd_at >= 0), 1);
        check("wd_window", 32'(wd_at >= 225 && wd_at <= 232), 1);
        check("wd_locked", 32'(locked_o), 0);
        check("wd_err_cnt", err_cnt, 3);
        check_tuple("wd_hold", 28, 3, 16, 13, 2, 6);
        err_before = err_cnt;
        idle(300);
        check("wd_search_quiet", err_cnt, err_before);

        drive_frame(16, 1'b0);
        for (int l = 0; l < 3; l++) drive_line(16, 16, l < 2, 1'b0);
        check("fd_done", done_cnt, 13);
        check("fd_htotal", 32'(htotal_o), 28);
        #2;
        rst_n = 1'b0;
        #1;
        check_tuple("async_rst", 0, 0, 0, 0, 0, 0);
        check("async_rst_locked", 32'(locked_o), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_measure.md
# video_timing_measure

Receive-side timing analyser placed directly downstream of the sync generator (`output_timing`). It samples that stage's `hsync_o`/`vsync_o`/`de_o`, normalises sync polarity and measures horizontal and vertical geometry per frame. It publishes the measured geometry and declares lock after a programmable number of consecutive identical frames. Used both as an on-chip loopback checker and as the timing monitor for the board video output.

## Interface
- `CNT_W`, 16, width of all measurement counters and result outputs.
- `LOCK_FRAMES`, 2, consecutive identical frames required to assert lock (1..15).

Ports:
- `clk`  in  1  pixel clock, same clock as the sync generator.
- `rst_n`  in  1  asynchronous, active-low reset; one clock domain, no other clocks.
- `en_i`  in  1  measurement enable; low forces IDLE.
- `hpol_i`  in  1  sync polarity for both syncs: 1 = active-high, 0 = active-low.
- `hsync_i`, `vsync_i`, `de_i`  in  1 each  raw timing inputs.
- `htotal_o`  out  CNT_W  clocks between consecutive hsync leading edges.
- `hsw_o`  out  CNT_W  clocks hsync asserted.
- `hactive_o`  out  CNT_W  de-high clocks per active line.
- `vtotal_o`  out  CNT_W  hsync leading edges per frame.
- `vsw_o`  out  CNT_W  hsync leading edges while vsync asserted.
- `vactive_o`  out  CNT_W  lines containing at least one de-high clock.
- `locked_o`  out  1  geometry stable.
- `frame_done_o`  out  1  one-clock pulse when results are published.
- `err_o`  out  1  one-clock pulse on lock loss or watchdog timeout.

## Operation
- Input stage: a single register stage holds `hs_n = hsync_i ^ ~hpol_i`, `vs_n` (same XOR form), and `de`. A second register holds the previous values. Leading edge = current & ~previous.
- Counters (all saturate at all-ones, never wrap):
  - `pix_cnt` is cleared to 1 on each hsync leading edge and increments otherwise.
  - `hsw_cnt` counts clocks with `hs_n` high in the current line.
  - `de_cnt` counts clocks with `de` high in the current line.
  - `line_cnt`, `vsw_cnt` and `vact_cnt` accumulate per frame.
- Line close (hsync leading edge):
  - Latch `pix_cnt` and `hsw_cnt` as the line's htotal/hsw.
  - `line_cnt`++.
  - If `vs_n` is high, including an edge coincident with the vsync leading edge, `vsw_cnt`++.
  - If `de_cnt` > 0, `vact_cnt`++. That line's `de_cnt` becomes the frame hactive. If it differs from an earlier active line in the same frame, set `frame_bad`.
- Frame close (vsync leading edge): the frame tuple is {htotal, hsw, hactive, line_cnt, vsw_cnt, vact_cnt}.
- State machine:
  - IDLE: entered on reset or whenever `en_i` = 0 (from any state, next clock). Counters, outputs and `match_cnt` are cleared. Exits to SEARCH when `en_i` = 1.
  - SEARCH: waits for a vsync leading edge, clears frame counters at that edge, then goes to MEASURE. Nothing is published.
  - MEASURE: at each frame close, publish the tuple to the outputs and pulse `frame_done_o`.
    - Tuple equals the previous published tuple and `frame_bad` = 0: `match_cnt`++.
    - Otherwise: `match_cnt` = 1, or 0 if `frame_bad` = 1.
    - The first published frame sets `match_cnt` = 1.
    - `match_cnt` == `LOCK_FRAMES`: go to LOCKED and set `locked_o`.
  - LOCKED: publish as in MEASURE. A mismatch or `frame_bad` clears `locked_o`, pulses `err_o`, sets `match_cnt` = 1 (0 if bad), and returns to MEASURE.
- Watchdog: `pix_cnt` reaching all-ones in MEASURE or LOCKED means no hsync. Pulse `err_o`, clear `locked_o`, go to SEARCH. Published outputs hold.
- Simultaneous hsync and vsync leading edges: the line close executes first, and its line is counted in the closing frame.

## Timing
- Reset values: all outputs 0, state IDLE.
- Input sampled at clock edge k. The edge is detected during cycle k→k+1, and results register at edge k+1. Outputs therefore change 2 clocks after the first sampling of the vsync leading edge.
- `frame_done_o`, `err_o` and `locked_o` change on the same edge as the outputs.
- `en_i` low, or `rst_n` low mid-frame: IDLE with outputs zero on the next edge; reset acts asynchronously.

## Test plan
- Reset, then `en_i` = 1 with no syncs: all outputs stay 0. After 65535 clocks in SEARCH there is no `err_o` (watchdog is active only in MEASURE/LOCKED).
- 720x480 stream (hfp/hsw/hbp 20/10/20, vfp/vsw/vbp 20/10/20, `hpol_i` = 0, active-low syncs) -> outputs 770/10/720/530/10/480. `frame_done_o` fires at each vsync edge. `locked_o` rises at the 3rd vsync leading edge with `LOCK_FRAMES` = 2.
- Same geometry with active-high syncs and `hpol_i` = 1 -> identical results and lock timing.
- While locked, switch hactive to 640 -> `err_o` pulse and `locked_o` = 0 at the next frame close. Relock with 690/640 two frames later.
- While locked, hold hsync inactive -> `err_o` pulse and `locked_o` = 0 65535 clocks after the last hsync edge. State SEARCH, outputs hold.
- Drop `en_i` mid-frame -> outputs 0 the next clock. Re-enabling gives a fresh lock after 3 vsync edges. An `rst_n` pulse mid-frame clears outputs immediately.
